id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline boundary of the 5-stage RV32I core. It registers decoded operands, immediate, register indices, the ALU selector fields and the control bits from ID. Those registered fields drive the EX stage: the ALU controller (ALUOp/Funct3/Funct7) and the ALU/forwarding logic. The block also detects load-use hazards, inserts bubbles, applies branch flushes and honours EX hold requests, and it keeps saturating bubble and flush counters for performance analysis.

## Interface
- DATA_W, 32, operand/PC/immediate width
- CNT_W, 16, width of each performance counter
- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state
- id_valid  in  1  ID holds a valid instruction
- id_pc  in  DATA_W  PC of ID instruction
- id_rd1  in  DATA_W  register-file read data, rs1
- id_rd2  in  DATA_W  register-file read data, rs2
- id_imm  in  DATA_W  sign-extended immediate
- id_rs  in  15  {rs1[14:10], rs2[9:5], rd[4:0]}
- id_fn  in  12  {funct7[11:5], funct3[4:2], alu_op[1:0]}
- id_ctrl  in  6  [0] alu_src, [1] mem_read, [2] mem_write, [3] reg_write, [4] mem_to_reg, [5] branch
- flush  in  1  taken branch/jump resolved in EX; kill ID and EX contents
- ex_hold  in  1  EX busy; freeze this register
- ex_valid  out  1  EX holds a valid instruction
- ex_pc, ex_rd1, ex_rd2, ex_imm  out  DATA_W each  registered copies
- ex_rs  out  15  registered id_rs
- ex_fn  out  12  registered id_fn; ex_fn[1:0] is ALUOp, ex_fn[4:2] is Funct3, ex_fn[11:5] is Funct7 to the ALU controller
- ex_ctrl  out  6  registered id_ctrl
- stall_id  out  1  combinational; IF/ID must hold this cycle
- bubble_cnt  out  CNT_W  load-use bubbles inserted, saturating
- flush_cnt  out  CNT_W  flush cycles, saturating

## Operation
- load_use = id_valid & ex_valid & ex_ctrl[1] & (ex_rs[4:0] != 0) & (ex_rs[4:0] == id_rs[14:10] | ex_rs[4:0] == id_rs[9:5]).
- Both rs fields are compared regardless of format. Spurious stalls for LUI/JAL/I-type are accepted, required behaviour.
- stall_id = ~flush & (ex_hold | load_use).
- The next-state action is chosen by strict priority. Only the first matching row applies:
  1. reset: every output register, counter and ex_valid goes to 0.
  2. flush: load a bubble. If CNT_W-wide flush_cnt is not all-ones, flush_cnt += 1.
  3. ex_hold: all EX registers retain their value. Counters unchanged.
  4. load_use: load a bubble. bubble_cnt += 1, saturating.
  5. otherwise: load all id_* fields. ex_valid <= id_valid.
- Bubble: ex_valid, ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_fn and ex_ctrl all become 0. An all-zero ex_fn presents ALUOp=00 (add) to the ALU controller, which is harmless.
- If id_valid=0 under normal load, the data fields still load, ex_valid=0 and ex_ctrl is forced to 0. No store or writeback escapes from an invalid slot.
- Counters saturate at 2^CNT_W-1 and never wrap.

## Timing
- Register latency is 1 cycle: ID values at edge N are visible on ex_* after edge N.
- stall_id is valid in the same cycle as its inputs, with no register. It depends only on current ex_* state, id_*, flush and ex_hold.
- A load-use stall lasts exactly 1 cycle. After the bubble, ex_ctrl[1]=0, so load_use drops and the held ID instruction enters EX on the next edge.
- flush together with ex_hold: flush wins, the bubble loads and stall_id=0.
- flush together with load_use: flush wins and only flush_cnt increments.
- Reset asserted mid-stall or mid-hold: outputs are 0 after the edge. stall_id=0 while ex_valid=0 and ex_hold=0.
- The reset value of every output is 0.

## Test plan
- Back-to-back independent adds: PC 0x0,0x4,0x8 with id_valid=1 and no hazards. ex_pc follows one cycle later, stall_id never rises, both counters stay 0.
- LW x5 then ADD x6,x5,x1: stall_id=1 for exactly 1 cycle, EX receives a bubble (ex_ctrl=0, ex_valid=0), then ADD enters EX. bubble_cnt=1.
- LW x0 then ADD x6,x0,x1: no stall, because rd=0 is exempt. bubble_cnt=0.
- flush pulse while ADD in ID and LW x5 in EX with a dependent instruction: ex_valid=0 next cycle, stall_id=0 during the flush cycle, flush_cnt=1, bubble_cnt=0.
- ex_hold held 3 cycles with SUB in EX (ex_fn={7'h20,3'b000,2'b10}): ex_fn unchanged throughout, stall_id=1 for all 3 cycles. SUB advances on the cycle after hold drops.
- Force 65537 load-use events (CNT_W=16): bubble_cnt saturates at 0xFFFF. A subsequent reset cycle returns all outputs to 0.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage RV32I core.
// Detects load-use hazards, inserts bubbles, applies flushes and holds, and counts events.
module id_ex_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_pc,
    input  logic [DATA_W-1:0] id_rd1,
    input  logic [DATA_W-1:0] id_rd2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [14:0]       id_rs,
    input  logic [11:0]       id_fn,
    input  logic [5:0]        id_ctrl,
    input  logic              flush,
    input  logic              ex_hold,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_pc,
    output logic [DATA_W-1:0] ex_rd1,
    output logic [DATA_W-1:0] ex_rd2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [14:0]       ex_rs,
    output logic [11:0]       ex_fn,
    output logic [5:0]        ex_ctrl,
    output logic              stall_id,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam int unsigned PayW = 4 * DATA_W + 33;

    logic [PayW-1:0]  payload_q, payload_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] bubble_q, bubble_d;
    logic [CNT_W-1:0] flush_q, flush_d;
    logic             rd_hit;
    logic             load_use;

    assign {ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_fn, ex_ctrl} = payload_q;
    assign ex_valid   = valid_q;
    assign bubble_cnt = bubble_q;
    assign flush_cnt  = flush_q;

    // Both source fields are compared for every format; spurious stalls are accepted.
    assign rd_hit   = (ex_rs[4:0] == id_rs[14:10]) | (ex_rs[4:0] == id_rs[9:5]);
    assign load_use = id_valid & valid_q & ex_ctrl[1] & (ex_rs[4:0] != 5'd0) & rd_hit;
    assign stall_id = ~flush & (ex_hold | load_use);

    always_comb begin
        payload_d = payload_q;
        valid_d   = valid_q;
        bubble_d  = bubble_q;
        flush_d   = flush_q;
        if (flush) begin
            payload_d = '0;
            valid_d   = 1'b0;
            if (~&flush_q) flush_d = flush_q + CNT_W'(1);
        end else if (ex_hold) begin
            // Freeze everything.
        end else if (load_use) begin
            payload_d = '0;
            valid_d   = 1'b0;
            if (~&bubble_q) bubble_d = bubble_q + CNT_W'(1);
        end else begin
            // An invalid slot still carries data but never any control side effects.
            payload_d = {id_pc, id_rd1, id_rd2, id_imm, id_rs, id_fn,
                         id_valid ? id_ctrl : 6'b0};
            valid_d   = id_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            payload_q <= '0;
            valid_q   <= 1'b0;
            bubble_q  <= '0;
            flush_q   <= '0;
        end else begin
            payload_q <= payload_d;
            valid_q   <= valid_d;
            bubble_q  <= bubble_d;
            flush_q   <= flush_d;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed hazard scenarios plus randomized traffic
// against a behavioural model; a narrow-counter instance exercises saturation.
module tb_id_ex_stage;

    localparam int unsigned DW = 32;
    localparam logic [11:0] FnAdd  = 12'h002;
    localparam logic [11:0] FnSub  = 12'h402;
    localparam logic [11:0] FnLw   = 12'h008;
    localparam logic [5:0]  CtlAdd = 6'h08;
    localparam logic [5:0]  CtlLw  = 6'h1b;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, id_valid, flush, ex_hold;
    logic [DW-1:0] id_pc, id_rd1, id_rd2, id_imm;
    logic [14:0]   id_rs;
    logic [11:0]   id_fn;
    logic [5:0]    id_ctrl;

    logic          ex_valid, stall_id, ex_valid_s, stall_id_s;
    logic [DW-1:0] ex_pc, ex_rd1, ex_rd2, ex_imm, ex_pc_s, ex_rd1_s, ex_rd2_s, ex_imm_s;
    logic [14:0]   ex_rs, ex_rs_s;
    logic [11:0]   ex_fn, ex_fn_s;
    logic [5:0]    ex_ctrl, ex_ctrl_s;
    logic [15:0]   bubble_cnt, flush_cnt;
    logic [3:0]    bubble_cnt_s, flush_cnt_s;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc), .id_rd1(id_rd1),
        .id_rd2(id_rd2), .id_imm(id_imm), .id_rs(id_rs), .id_fn(id_fn), .id_ctrl(id_ctrl),
        .flush(flush), .ex_hold(ex_hold), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_fn(ex_fn),
        .ex_ctrl(ex_ctrl), .stall_id(stall_id), .bubble_cnt(bubble_cnt),
        .flush_cnt(flush_cnt)
    );

    id_ex_stage #(.DATA_W(DW), .CNT_W(4)) dut_s (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc), .id_rd1(id_rd1),
        .id_rd2(id_rd2), .id_imm(id_imm), .id_rs(id_rs), .id_fn(id_fn), .id_ctrl(id_ctrl),
        .flush(flush), .ex_hold(ex_hold), .ex_valid(ex_valid_s), .ex_pc(ex_pc_s),
        .ex_rd1(ex_rd1_s), .ex_rd2(ex_rd2_s), .ex_imm(ex_imm_s), .ex_rs(ex_rs_s),
        .ex_fn(ex_fn_s), .ex_ctrl(ex_ctrl_s), .stall_id(stall_id_s),
        .bubble_cnt(bubble_cnt_s), .flush_cnt(flush_cnt_s)
    );

    int tests  = 0;
    int failed = 0;

    // Reference model: contents of the EX slot and event totals since the last reset.
    logic          m_valid;
    logic [DW-1:0] m_pc, m_rd1, m_rd2, m_imm;
    logic [14:0]   m_rs;
    logic [11:0]   m_fn;
    logic [5:0]    m_ctrl;
    int            n_bub, n_fl;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            failed++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic m_load_use();
        logic [4:0] rd;
        rd = m_rs[4:0];
        return id_valid && m_valid && m_ctrl[1] && rd != 5'd0 &&
               (rd == id_rs[14:10] || rd == id_rs[9:5]);
    endfunction

    function automatic int sat(input int n, input int maxv);
        return (n > maxv) ? maxv : n;
    endfunction

    task automatic m_clear();
        m_valid = 1'b0; m_pc = '0; m_rd1 = '0; m_rd2 = '0; m_imm = '0;
        m_rs = '0; m_fn = '0; m_ctrl = '0;
    endtask

    task automatic m_step();
        if (reset) begin
            m_clear();
            n_bub = 0;
            n_fl  = 0;
        end else if (flush) begin
            m_clear();
            n_fl++;
        end else if (ex_hold) begin
            // slot frozen
        end else if (m_load_use()) begin
            m_clear();
            n_bub++;
        end else begin
            m_valid = id_valid; m_pc = id_pc; m_rd1 = id_rd1; m_rd2 = id_rd2;
            m_imm = id_imm; m_rs = id_rs; m_fn = id_fn;
            m_ctrl = id_valid ? id_ctrl : 6'b0;
        end
    endtask

    task automatic check_outputs();
        chk("ex_valid", 64'(ex_valid), 64'(m_valid));
        chk("ex_pc", 64'(ex_pc), 64'(m_pc));
        chk("ex_rd1", 64'(ex_rd1), 64'(m_rd1));
        chk("ex_rd2", 64'(ex_rd2), 64'(m_rd2));
        chk("ex_imm", 64'(ex_imm), 64'(m_imm));
        chk("ex_rs", 64'(ex_rs), 64'(m_rs));
        chk("ex_fn", 64'(ex_fn), 64'(m_fn));
        chk("ex_ctrl", 64'(ex_ctrl), 64'(m_ctrl));
        chk("bubble_cnt", 64'(bubble_cnt), 64'(sat(n_bub, 65535)));
        chk("flush_cnt", 64'(flush_cnt), 64'(sat(n_fl, 65535)));
        chk("ex_slot_s", {ex_valid_s, ex_pc_s, ex_rs_s, ex_fn_s, ex_ctrl_s},
            {m_valid, m_pc, m_rs, m_fn, m_ctrl});
        chk("bubble_cnt_s", 64'(bubble_cnt_s), 64'(sat(n_bub, 15)));
        chk("flush_cnt_s", 64'(flush_cnt_s), 64'(sat(n_fl, 15)));
    endtask

    // One clock: check the combinational stall, take the edge, then check registered state.
    task automatic tick();
        logic exp_stall;
        #1;
        exp_stall = !flush && (ex_hold || m_load_use());
        chk("stall_id", 64'(stall_id), 64'(exp_stall));
        chk("stall_id_s", 64'(stall_id_s), 64'(exp_stall));
        @(posedge clk);
        m_step();
        #1;
        check_outputs();
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] pc, input logic [4:0] r1,
                         input logic [4:0] r2, input logic [4:0] rd, input logic [11:0] fn,
                         input logic [5:0] ctrl);
        id_valid = v; id_pc = pc; id_rs = {r1, r2, rd}; id_fn = fn; id_ctrl = ctrl;
        id_rd1 = $urandom; id_rd2 = $urandom; id_imm = $urandom;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; ex_hold = 1'b0;
        drive(1'b0, '0, 5'd0, 5'd0, 5'd0, 12'h0, 6'h0);
        m_clear(); n_bub = 0; n_fl = 0;
        @(posedge clk); #1;
        tick();
        chk("reset_valid", 64'(ex_valid), 64'd0);
        chk("reset_cnt", 64'({bubble_cnt, flush_cnt}), 64'd0);
        reset = 1'b0;

        // Back-to-back independent adds
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, DW'(4 * i), 5'd10, 5'd11, 5'(i + 1), FnAdd, CtlAdd);
            tick();
            chk("add_pc", 64'(ex_pc), 64'(4 * i));
        end
        chk("add_cnts", 64'({bubble_cnt, flush_cnt}), 64'd0);

        // LW x5 then dependent ADD x6,x5,x1
        drive(1'b1, 32'h10, 5'd2, 5'd0, 5'd5, FnLw, CtlLw);
        tick();
        drive(1'b1, 32'h14, 5'd5, 5'd1, 5'd6, FnAdd, CtlAdd);
        #1 chk("lu_stall", 64'(stall_id), 64'd1);
        tick();
        chk("lu_bubble", 64'({ex_valid, ex_ctrl}), 64'd0);
        tick();
        chk("lu_enter", 64'(ex_pc), 64'h14);
        chk("lu_count", 64'(bubble_cnt), 64'd1);

        // LW x0 is exempt
        drive(1'b1, 32'h18, 5'd2, 5'd0, 5'd0, FnLw, CtlLw);
        tick();
        drive(1'b1, 32'h1c, 5'd0, 5'd1, 5'd6, FnAdd, CtlAdd);
        #1 chk("x0_nostall", 64'(stall_id), 64'd0);
        tick();
        chk("x0_enter", 64'(ex_pc), 64'h1c);

        // Flush beats a pending load-use
        drive(1'b1, 32'h20, 5'd2, 5'd0, 5'd5, FnLw, CtlLw);
        tick();
        drive(1'b1, 32'h24, 5'd5, 5'd1, 5'd6, FnAdd, CtlAdd);
        flush = 1'b1;
        #1 chk("fl_nostall", 64'(stall_id), 64'd0);
        tick();
        flush = 1'b0;
        chk("fl_valid", 64'(ex_valid), 64'd0);
        chk("fl_cnts", 64'({bubble_cnt, flush_cnt}), {32'd0, 16'd1, 16'd1});

        // SUB held in EX for 3 cycles
        drive(1'b1, 32'h28, 5'd7, 5'd8, 5'd9, FnSub, CtlAdd);
        tick();
        drive(1'b1, 32'h2c, 5'd1, 5'd2, 5'd3, FnAdd, CtlAdd);
        ex_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("hold_stall", 64'(stall_id), 64'd1);
            tick();
            chk("hold_fn", 64'(ex_fn), 64'(FnSub));
        end
        ex_hold = 1'b0;
        tick();
        chk("hold_release", 64'(ex_pc), 64'h2c);

        // Randomized traffic with a small register space to provoke hazards
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 3) != 0), $urandom, 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 12'($urandom),
                  6'($urandom));
            flush   = ($urandom_range(0, 7) == 0);
            ex_hold = ($urandom_range(0, 7) == 0);
            reset   = ($urandom_range(0, 49) == 0);
            tick();
        end
        flush = 1'b0; ex_hold = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;

        // Saturation: narrow instance tops out at 15, wide one keeps counting
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 32'h40, 5'd2, 5'd0, 5'd5, FnLw, CtlLw);
            tick();
            drive(1'b1, 32'h44, 5'd1, 5'd5, 5'd6, FnAdd, CtlAdd);
            tick();
        end
        chk("sat_bub_s", 64'(bubble_cnt_s), 64'd15);
        chk("sat_bub", 64'(bubble_cnt), 64'd20);
        flush = 1'b1;
        repeat (20) tick();
        flush = 1'b0;
        chk("sat_fl_s", 64'(flush_cnt_s), 64'd15);
        chk("sat_fl", 64'(flush_cnt), 64'd20);

        // Reset mid-stall and mid-hold
        drive(1'b1, 32'h48, 5'd2, 5'd0, 5'd5, FnLw, CtlLw);
        tick();
        drive(1'b1, 32'h4c, 5'd5, 5'd1, 5'd6, FnAdd, CtlAdd);
        ex_hold = 1'b1; reset = 1'b1;
        tick();
        chk("rst_outs", {ex_valid, ex_pc, ex_ctrl, ex_fn, bubble_cnt_s}, 64'd0);
        chk("rst_cnts", 64'({bubble_cnt, flush_cnt}), 64'd0);
        ex_hold = 1'b0;
        #1 chk("rst_nostall", 64'(stall_id), 64'd0);
        reset = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
